multi_debounce: RTL and testbench

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

---
 rtl/multi_debounce.sv | 112 +++++++++++
 tb/tb_multi_debounce.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// Multi-channel debouncer: per-channel stability counter, registered level,
// one-cycle rise/fall pulses and a combined any_change flag.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   sample_en      sample strobe, counters advance only when high
//   data_in        raw inputs, one bit per channel
//   data_debounced registered stable levels
//   rise / fall    one-cycle pulses on debounced 0->1 / 1->0
//   any_change     registered OR of rise|fall
//
// Optional macro DEBOUNCE_SYNC_EN adds a 2-flop synchroniser per channel
// ahead of the comparison (+2 edges latency).
module multi_debounce #(
  parameter int CHANNELS = 4,
  parameter int CNT_WIDTH = 16,
  parameter int THRESHOLD = 2**CNT_WIDTH-1,
  parameter logic [CHANNELS-1:0] RST_LEVEL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] data_in,
  output logic [CHANNELS-1:0] data_debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(THRESHOLD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CHANNELS-1:0] samp;

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RST_LEVEL;
      sync2_q <= RST_LEVEL;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = data_in;
`endif

  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]  level_q, level_d;
  logic [CHANNELS-1:0]  rise_q, rise_d;
  logic [CHANNELS-1:0]  fall_q, fall_d;
  logic                 any_q, any_d;
  logic [CHANNELS-1:0]  accept;

  // A match clears the count even without a strobe, so a bounce back
  // to the current level always restarts the run from zero.
  always_comb begin
    level_d = level_q;
    accept  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (samp[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (sample_en) begin
        if (cnt_q[i] == CNT_LAST) begin
          accept[i]  = 1'b1;
          level_d[i] = samp[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    rise_d = accept & samp;
    fall_d = accept & ~samp;
    any_d  = |accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= RST_LEVEL;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
    end
  end

  assign data_debounced = level_q;
  assign rise           = rise_q;
  assign fall           = fall_q;
  assign any_change     = any_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Testbench for multi_debounce: three instances (THRESHOLD 8 / RST 0000,
// THRESHOLD 8 / RST 0101, THRESHOLD 1 / RST 0000) against a run-length model.
module tb_multi_debounce;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SX = 2;
`else
  localparam int SX = 0;
`endif

  logic       clk;
  logic       reset;
  logic       sample_en;
  logic [3:0] data_in;
  logic [3:0] deb  [3];
  logic [3:0] rise [3];
  logic [3:0] fall [3];
  logic       anyc [3];

  int n_chk;
  int n_fail;
  bit chk_en;

  multi_debounce #(
    .CHANNELS(4), .CNT_WIDTH(4), .THRESHOLD(8), .RST_LEVEL(4'b0000)
  ) u0 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .data_in(data_in),
    .data_debounced(deb[0]), .rise(rise[0]), .fall(fall[0]),
    .any_change(anyc[0])
  );

  multi_debounce #(
    .CHANNELS(4), .CNT_WIDTH(4), .THRESHOLD(8), .RST_LEVEL(4'b0101)
  ) u1 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .data_in(data_in),
    .data_debounced(deb[1]), .rise(rise[1]), .fall(fall[1]),
    .any_change(anyc[1])
  );

  multi_debounce #(
    .CHANNELS(4), .CNT_WIDTH(4), .THRESHOLD(1), .RST_LEVEL(4'b0000)
  ) u2 (
    .clk(clk), .reset(reset), .sample_en(sample_en), .data_in(data_in),
    .data_debounced(deb[2]), .rise(rise[2]), .fall(fall[2]),
    .any_change(anyc[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per channel, the stable level and the number of consecutive
  // strobed samples that disagreed with it.
  int         thr [3] = '{8, 8, 1};
  logic [3:0] rl  [3] = '{4'b0000, 4'b0101, 4'b0000};
  logic [3:0] m_lvl  [3];
  logic [3:0] m_rise [3];
  logic [3:0] m_fall [3];
  logic       m_any  [3];
  logic [3:0] m_s1   [3];
  logic [3:0] m_s2   [3];
  int         m_run  [3][4];

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_lvl[k]  = rl[k];
      m_rise[k] = '0;
      m_fall[k] = '0;
      m_any[k]  = 1'b0;
      m_s1[k]   = rl[k];
      m_s2[k]   = rl[k];
      for (int c = 0; c < 4; c++) m_run[k][c] = 0;
    end
  endtask

  task automatic m_step();
    logic [3:0] s;
    if (reset) begin
      m_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        s = (SX != 0) ? m_s2[k] : data_in;
        m_rise[k] = '0;
        m_fall[k] = '0;
        for (int c = 0; c < 4; c++) begin
          if (s[c] == m_lvl[k][c]) begin
            m_run[k][c] = 0;
          end else if (sample_en) begin
            if (m_run[k][c] + 1 >= thr[k]) begin
              m_lvl[k][c] = s[c];
              m_run[k][c] = 0;
              if (s[c]) m_rise[k][c] = 1'b1;
              else      m_fall[k][c] = 1'b1;
            end else begin
              m_run[k][c] = m_run[k][c] + 1;
            end
          end
        end
        m_any[k] = |(m_rise[k] | m_fall[k]);
        m_s2[k] = m_s1[k];
        m_s1[k] = data_in;
      end
    end
  endtask

  always @(posedge clk) m_step();

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("deb%0d", k),  32'(deb[k]),  32'(m_lvl[k]));
        chk($sformatf("rise%0d", k), 32'(rise[k]), 32'(m_rise[k]));
        chk($sformatf("fall%0d", k), 32'(fall[k]), 32'(m_fall[k]));
        chk($sformatf("any%0d", k),  32'(anyc[k]), 32'(m_any[k]));
      end
    end
  end

  // Applies inputs for one rising edge; returns just after the next
  // falling edge, when the outputs of that edge are settled.
  task automatic drive(input logic [3:0] d, input logic en);
    data_in   = d;
    sample_en = en;
    @(negedge clk);
    #2;
  endtask

  task automatic hold(input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) drive(d, 1'b1);
  endtask

  int quiet;

  initial begin
    n_chk = 0;
    n_fail = 0;
    chk_en = 1'b0;
    reset = 1'b1;
    sample_en = 1'b0;
    data_in = 4'b0000;
    m_reset();
    @(negedge clk);
    #2;
    chk("rst_deb0", 32'(deb[0]), 32'h0);
    chk("rst_deb1", 32'(deb[1]), 32'h5);
    chk("rst_pulse", 32'({rise[1], fall[1], anyc[1]}), 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Single channel rise after THRESHOLD edges.
    hold(4'b0001, 7 + SX);
    chk("r029_early", 32'(deb[0][0]), 32'h0);
    hold(4'b0001, 1);
    chk("r029_deb", 32'(deb[0][0]), 32'h1);
    chk("r029_rise", 32'(rise[0]), 32'h1);
    chk("r029_any", 32'(anyc[0]), 32'h1);
    hold(4'b0001, 1);
    chk("r029_rise_end", 32'(rise[0]), 32'h0);
    chk("r029_any_end", 32'(anyc[0]), 32'h0);

    // Bounce of 7 high, 1 low, 7 high never qualifies.
    quiet = 0;
    for (int i = 0; i < 15 + SX + 2; i++) begin
      drive((i < 7 || (i > 7 && i < 15)) ? 4'b0011 : 4'b0001, 1'b1);
      quiet += int'(rise[0][1] | fall[0][1] | anyc[0]);
    end
    chk("r030_quiet", 32'(quiet), 32'h0);
    chk("r030_deb", 32'(deb[0]), 32'h1);

    // All channels at once.
    hold(4'b0000, 10 + SX);
    hold(4'b1111, 7 + SX);
    chk("r031_early", 32'(rise[0]), 32'h0);
    hold(4'b1111, 1);
    chk("r031_rise", 32'(rise[0]), 32'hf);
    chk("r031_any", 32'(anyc[0]), 32'h1);
    hold(4'b1111, 1);
    chk("r031_any_end", 32'(anyc[0]), 32'h0);
    chk("r031_deb", 32'(deb[0]), 32'hf);

    // Strobe every 4th cycle.
    hold(4'b0000, 10 + SX);
    for (int i = 0; i < 32; i++) begin
      drive(4'b0100, (i % 4) == 3);
      if (i == 30) chk("r032_early", 32'(deb[0][2]), 32'h0);
    end
    chk("r032_deb", 32'(deb[0][2]), 32'h1);
    chk("r032_rise", 32'(rise[0]), 32'h4);

    // Reset mid-count, then a full count is needed.
    hold(4'b0000, 10 + SX);
    hold(4'b1010, 5 + SX);
    reset = 1'b1;
    m_reset();
    #1;
    chk("r033_deb1", 32'(deb[1]), 32'h5);
    chk("r033_deb0", 32'(deb[0]), 32'h0);
    chk("r033_pulse", 32'({rise[1], fall[1], anyc[1]}), 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    hold(4'b1010, 7 + SX);
    chk("r033_early", 32'(deb[1]), 32'h5);
    hold(4'b1010, 1);
    chk("r033_deb", 32'(deb[1]), 32'ha);
    chk("r033_fall", 32'(fall[1]), 32'h5);
    chk("r033_rise", 32'(rise[1]), 32'ha);

    // THRESHOLD=1 fall on channel 3.
    hold(4'b1000, 3 + SX);
    for (int i = 1; i <= SX + 1; i++) begin
      drive(4'b0000, 1'b1);
      chk("r034_fall", 32'(fall[2]), (i == SX + 1) ? 32'h8 : 32'h0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        m_reset();
        drive(data_in, sample_en);
        reset = 1'b0;
      end
      drive(($urandom_range(0, 7) == 0) ? 4'($urandom) : data_in,
            $urandom_range(0, 3) != 0);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
